// File: rtl/shift_ctrl8_if.sv
// Command/op handshake bundle between the command source,
// the shift controller and the shifter op/shamt inputs.
interface shift_ctrl8_if;
   logic       i_valid;
   logic [1:0] i_cmd;
   logic [4:0] i_amount;
   logic       o_ready;
   logic [2:0] o_op;
   logic [1:0] o_shamt;
   logic       o_busy;
   logic       o_done;

   modport master (
      output i_valid, i_cmd, i_amount,
      input  o_ready, o_op, o_shamt, o_busy, o_done
   );

   modport slave (
      input  i_valid, i_cmd, i_amount,
      output o_ready, o_op, o_shamt, o_busy, o_done
   );
endinterface

// File: rtl/shift_ctrl8.sv
// Sequencer issuing LOAD / shift / done op cycles to the
// 8-bit shifter for one command of 0-31 positions.
module shift_ctrl8 (
   input  logic          clk,
   input  logic          reset_n,
   shift_ctrl8_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t     state, state_n;
   logic [3:0] rem, rem_n;
   logic [1:0] cmd, cmd_n;
   logic [1:0] step;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         rem   <= 4'd0;
         cmd   <= 2'd0;
      end else begin
         state <= state_n;
         rem   <= rem_n;
         cmd   <= cmd_n;
      end
   end

   // Amounts of 8 or more give the same result as 8
   assign step = (rem > 4'd3) ? 2'd3 : rem[1:0];

   always_comb begin
      state_n = state;
      rem_n   = rem;
      cmd_n   = cmd;
      unique case (state)
         IDLE: begin
            if (bus.i_valid) begin
               state_n = LOAD;
               cmd_n   = bus.i_cmd;
               if (bus.i_cmd == 2'b11)
                  rem_n = 4'd0;
               else if (bus.i_amount >= 5'd8)
                  rem_n = 4'd8;
               else
                  rem_n = bus.i_amount[3:0];
            end
         end
         LOAD: state_n = (rem == 4'd0) ? DONE : SHIFT;
         SHIFT: begin
            rem_n   = rem - {2'b00, step};
            state_n = (rem_n == 4'd0) ? DONE : SHIFT;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bus.o_ready = 1'b0;
      bus.o_op    = 3'b000;
      bus.o_shamt = 2'b00;
      bus.o_busy  = 1'b0;
      bus.o_done  = 1'b0;
      unique case (state)
         IDLE: bus.o_ready = 1'b1;
         LOAD: begin
            bus.o_op   = 3'b001;
            bus.o_busy = 1'b1;
         end
         SHIFT: begin
            bus.o_busy  = 1'b1;
            bus.o_shamt = step;
            unique case (1'b1)
               (cmd == 2'b00): bus.o_op = 3'b010;
               (cmd == 2'b01): bus.o_op = 3'b011;
               (cmd == 2'b10): bus.o_op = 3'b100;
               default:        bus.o_op = 3'b000;
            endcase
         end
         DONE: bus.o_done = 1'b1;
         default: bus.o_ready = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_shift_ctrl8.sv
// Directed bench for shift_ctrl8 with a behavioural
// 8-bit shifter register fed by the issued op/shamt.
module tb_shift_ctrl8;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic [7:0] d_in = 8'h00;
   logic [7:0] sq = 8'h00;
   int total = 0;
   int bad = 0;

   shift_ctrl8_if bus ();

   shift_ctrl8 dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      case (bus.o_op)
         3'b001: sq <= d_in;
         3'b010: sq <= sq << bus.o_shamt;
         3'b011: sq <= sq >> bus.o_shamt;
         3'b100: sq <= $signed(sq) >>> bus.o_shamt;
         default: sq <= sq;
      endcase
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_chk(input string tag);
      check({tag, "_op"}, {29'd0, bus.o_op}, 32'd0);
      check({tag, "_sh"}, {30'd0, bus.o_shamt}, 32'd0);
      check({tag, "_rdy"}, {31'd0, bus.o_ready}, 32'd1);
      check({tag, "_busy"}, {31'd0, bus.o_busy}, 32'd0);
      check({tag, "_done"}, {31'd0, bus.o_done}, 32'd0);
   endtask

   task automatic wait_ready(input string tag);
      int k;
      k = 0;
      @(negedge clk);
      while (!bus.o_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!bus.o_ready)
         check({tag, "_rdy_to"}, 32'd0, 32'd1);
   endtask

   // seq entry k at [k*5 +: 5] = {op, shamt}
   task automatic run_seq(input string tag,
                          input logic [1:0] cmd,
                          input logic [4:0] amt,
                          input logic [7:0] d,
                          input bit hold,
                          input int exp_n,
                          input logic [19:0] exp_seq,
                          input logic [7:0] exp_res,
                          input int exp_busy);
      logic [4:0] seq [$];
      int busy_n, loads, viol, k;
      bit got_done;
      busy_n = 0;
      loads = 0;
      viol = 0;
      got_done = 0;
      wait_ready(tag);
      d_in = d;
      bus.i_valid = 1'b1;
      bus.i_cmd = cmd;
      bus.i_amount = amt;
      @(posedge clk);
      #1;
      if (!hold) bus.i_valid = 1'b0;
      for (k = 0; k < 16 && !got_done; k++) begin
         @(negedge clk);
         if (bus.o_ready !== ~(bus.o_busy | bus.o_done))
            viol++;
         if (bus.o_busy) busy_n++;
         if (bus.o_done) begin
            got_done = 1;
            bus.i_valid = 1'b0;
            check({tag, "_res"}, {24'd0, sq}, {24'd0, exp_res});
         end else begin
            if (bus.o_op == 3'b001) loads++;
            seq.push_back({bus.o_op, bus.o_shamt});
         end
      end
      check({tag, "_done_seen"}, {31'd0, got_done}, 32'd1);
      check({tag, "_len"}, seq.size(), exp_n);
      for (int i = 0; i < exp_n && i < seq.size(); i++)
         check($sformatf("%s_step%0d", tag, i),
               {27'd0, seq[i]},
               {27'd0, exp_seq[i*5 +: 5]});
      check({tag, "_busy_cyc"}, busy_n, exp_busy);
      check({tag, "_loads"}, loads, 1);
      check({tag, "_excl"}, viol, 0);
   endtask

   initial begin
      bus.i_valid = 1'b0;
      bus.i_cmd = 2'b00;
      bus.i_amount = 5'd0;
      #13;
      reset_n = 1'b0;
      #1;
      idle_chk("rst_async");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      idle_chk("rst_idle");

      run_seq("lsl2", 2'b00, 5'd2, 8'hBC, 0, 2,
              {10'd0, 5'b01010, 5'b00100}, 8'hF0, 2);
      run_seq("lsr7", 2'b01, 5'd7, 8'hBC, 0, 4,
              {5'b01101, 5'b01111, 5'b01111, 5'b00100},
              8'h01, 4);
      run_seq("asr20", 2'b10, 5'd20, 8'hBC, 1, 4,
              {5'b10010, 5'b10011, 5'b10011, 5'b00100},
              8'hFF, 4);
      @(negedge clk);
      check("asr20_noreacc", {31'd0, bus.o_ready}, 32'd1);
      run_seq("lsr0", 2'b01, 5'd0, 8'hBC, 0, 1,
              {15'd0, 5'b00100}, 8'hBC, 1);
      run_seq("ld5", 2'b11, 5'd5, 8'h5A, 0, 1,
              {15'd0, 5'b00100}, 8'h5A, 1);
      run_seq("lsl31", 2'b00, 5'd31, 8'hFF, 0, 4,
              {5'b01010, 5'b01011, 5'b01011, 5'b00100},
              8'h00, 4);

      wait_ready("rsh");
      d_in = 8'hBC;
      bus.i_valid = 1'b1;
      bus.i_cmd = 2'b00;
      bus.i_amount = 5'd9;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      @(negedge clk);
      check("rsh_load", {29'd0, bus.o_op}, 32'd1);
      @(negedge clk);
      check("rsh_sh1", {27'd0, bus.o_op, bus.o_shamt}, 32'b01011);
      @(posedge clk);
      #3;
      check("rsh_sh2", {27'd0, bus.o_op, bus.o_shamt}, 32'b01011);
      reset_n = 1'b0;
      #1;
      idle_chk("rsh_async");
      begin
         int dn;
         dn = 0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.o_done) dn++;
         end
         reset_n = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.o_done) dn++;
         end
         check("rsh_nodone", dn, 0);
      end
      run_seq("lsr1", 2'b01, 5'd1, 8'hBC, 0, 2,
              {10'd0, 5'b01101, 5'b00100}, 8'h5E, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
